// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Byte-stream program loader. It parses a length-prefixed frame
//               of 18-bit instructions, writes them to instruction memory and
//               then releases the processor from reset.
//               Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN adds a
//               trailing XOR checksum byte to the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 18
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    input  logic               cpu_finish,
    output logic               cpu_reset,
    output logic               load_done,
    output logic               err
);

    typedef enum logic [3:0] {
        LEN_HI = 4'd0,
        LEN_LO = 4'd1,
        B0     = 4'd2,
        B1     = 4'd3,
        B2     = 4'd4,
        WRITE  = 4'd5,
        CHK    = 4'd6,
        RUN    = 4'd7,
        ERROR  = 4'd8
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [15:0]        len;
    logic [ADDR_W:0]    index;
    logic [1:0]         hi_bits;
    logic [7:0]         mid_byte;
    logic [INSTR_W-1:0] word;

    logic [15:0]        len_next;
    logic [ADDR_W:0]    index_inc;
    logic               len_bad;
    logic               more_words;

    assign len_next   = {len[15:8], rx_data};
    assign len_bad    = (len_next == 16'd0) || (32'(len_next) > (32'd1 << ADDR_W));
    assign index_inc  = index + 1'b1;
    assign more_words = 32'(index_inc) < 32'(len);

    assign imem_addr  = index[ADDR_W-1:0];
    assign imem_wdata = word;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_ok;

    assign csum_ok = (rx_data == csum);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum <= 8'd0;
        end else if (state == RUN && cpu_finish) begin
            csum <= 8'd0;
        end else if (rx_valid && (state == LEN_HI || state == LEN_LO ||
                                  state == B0 || state == B1 || state == B2)) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LEN_HI;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        rx_ready  = 1'b0;
        imem_we   = 1'b0;
        cpu_reset = 1'b1;
        load_done = 1'b0;
        err       = 1'b0;
        // Byte-accepting states have rx_ready=1, so rx_valid alone marks a transfer.
        case (state)
            LEN_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nx = LEN_LO;
            end
            LEN_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nx = len_bad ? ERROR : B0;
            end
            B0: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nx = (rx_data[7:2] != 6'd0) ? ERROR : B1;
            end
            B1: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nx = B2;
            end
            B2: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nx = WRITE;
            end
            WRITE: begin
                imem_we = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                state_nx = more_words ? B0 : CHK;
`else
                state_nx = more_words ? B0 : RUN;
`endif
            end
            CHK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                rx_ready = 1'b1;
                if (rx_valid) state_nx = csum_ok ? RUN : ERROR;
`else
                state_nx = ERROR;
`endif
            end
            RUN: begin
                cpu_reset = 1'b0;
                load_done = 1'b1;
                if (cpu_finish) state_nx = LEN_HI;
            end
            ERROR: begin
                err = 1'b1;
            end
            default: begin
                state_nx = ERROR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len      <= 16'd0;
            index    <= '0;
            hi_bits  <= 2'd0;
            mid_byte <= 8'd0;
            word     <= '0;
        end else begin
            case (state)
                LEN_HI: if (rx_valid) len[15:8] <= rx_data;
                LEN_LO: if (rx_valid) len[7:0]  <= rx_data;
                B0:     if (rx_valid) hi_bits   <= rx_data[1:0];
                B1:     if (rx_valid) mid_byte  <= rx_data;
                B2:     if (rx_valid) word      <= INSTR_W'({hi_bits, mid_byte, rx_data});
                WRITE:  index <= index_inc;
                RUN:    if (cpu_finish) index <= '0;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Randomised self-checking bench for program_loader against a
//               frame-level parsing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int ADDR_W = 10;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [17:0]       imem_wdata;
    logic              cpu_finish = 1'b0;
    logic              cpu_reset;
    logic              load_done;
    logic              err;

    int total = 0;
    int bad   = 0;

    logic [7:0]  stream[$];
    int          exp_addr[$];
    int          exp_data[$];
    int          obs_addr[$];
    int          obs_data[$];
    bit          exp_err;
    int          exp_consumed;
    logic        prev_we = 1'b0;

    program_loader #(.ADDR_W(ADDR_W), .INSTR_W(18)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_finish (cpu_finish),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Capture every write; a strobe longer than one cycle is an error.
    always @(negedge clk) begin
        if (imem_we) begin
            check("we_one_cycle", 32'(prev_we), 32'd0);
            obs_addr.push_back(int'(imem_addr));
            obs_data.push_back(int'(imem_wdata));
        end
        prev_we <= imem_we;
    end

    // Frame-level model: parse the byte stream and list the expected writes.
    task automatic model();
        int n;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        exp_err = 1'b0;
        n = int'(stream[0]) * 256 + int'(stream[1]);
        x = stream[0] ^ stream[1];
        exp_consumed = 2;
        if (n == 0 || n > (1 << ADDR_W)) begin
            exp_err = 1'b1;
            return;
        end
        for (int w = 0; w < n; w++) begin
            exp_consumed++;
            if (stream[2+3*w] > 8'd3) begin
                exp_err = 1'b1;
                return;
            end
            exp_consumed += 2;
            x = x ^ stream[2+3*w] ^ stream[3+3*w] ^ stream[4+3*w];
            exp_addr.push_back(w);
            exp_data.push_back(int'(stream[2+3*w]) * 65536 + int'(stream[3+3*w]) * 256 +
                               int'(stream[4+3*w]));
        end
        if (CSUM_EN) begin
            exp_consumed++;
            exp_err = (stream[2+3*n] != x);
        end
    endtask

    task automatic send_stream(input int count, input bit rand_valid);
        int i = 0;
        int guard = 0;
        while (i < count) begin
            @(negedge clk);
            rx_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            rx_data  = rx_valid ? stream[i] : 8'($urandom);
            #1;
            if (rx_valid && rx_ready) begin
                i++;
                guard = 0;
            end else if (++guard > 200) begin
                check("rx_stall", 32'd1, 32'd0);
                break;
            end
            @(posedge clk);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", 32'(imem_wdata), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_vals();
        @(negedge clk);
        reset = 1'b1;
        obs_addr.delete();
        obs_data.delete();
    endtask

    task automatic add_csum();
        logic [7:0] x = 8'd0;
        foreach (stream[i]) x ^= stream[i];
        if (CSUM_EN) stream.push_back(x);
    endtask

    task automatic build_random(input int n);
        logic [17:0] w;
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        for (int k = 0; k < n; k++) begin
            w = 18'($urandom);
            stream.push_back({6'd0, w[17:16]});
            stream.push_back(w[15:8]);
            stream.push_back(w[7:0]);
        end
        add_csum();
    endtask

    // Send the frame, compare writes and the final status against the model.
    task automatic run_frame(input bit rand_valid);
        model();
        obs_addr.delete();
        obs_data.delete();
        send_stream(exp_consumed, rand_valid);
        repeat (4) @(negedge clk);
        check("n_writes", 32'(obs_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            check("wr_addr", 32'(obs_addr[i]), 32'(exp_addr[i]));
            check("wr_data", 32'(obs_data[i]), 32'(exp_data[i]));
        end
        check("err", 32'(err), 32'(exp_err));
        check("load_done", 32'(load_done), 32'(!exp_err));
        check("cpu_reset", 32'(cpu_reset), 32'(exp_err));
        check("rx_ready_end", 32'(rx_ready), 32'd0);
    endtask

    task automatic finish_run();
        @(negedge clk);
        cpu_finish = 1'b1;
        @(posedge clk);
        #1;
        check("fin_cpu_reset", 32'(cpu_reset), 32'd1);
        check("fin_load_done", 32'(load_done), 32'd0);
        check("fin_addr_clr", 32'(imem_addr), 32'd0);
        check("fin_rx_ready", 32'(rx_ready), 32'd1);
        @(negedge clk);
        cpu_finish = 1'b0;
    endtask

    initial begin
        apply_reset();

        stream = {8'h00, 8'h01, 8'h03, 8'hFF, 8'hFF};
        add_csum();
        run_frame(1'b0);
        check("single_data", 32'(exp_data.size() > 0 ? exp_data[0] : 0), 32'h3FFFF);
        finish_run();

        stream = {8'h00, 8'h02, 8'h00, 8'h01, 8'h23, 8'h02, 8'hAB, 8'hCD};
        add_csum();
        run_frame(1'b1);
        finish_run();

        for (int t = 0; t < 6; t++) begin
            build_random($urandom_range(1, 8));
            run_frame(1'b1);
            finish_run();
        end

        build_random(1024);
        run_frame(1'b0);
        finish_run();

        stream = {8'h00, 8'h00};
        run_frame(1'b0);
        apply_reset();
        stream = {8'h04, 8'h01};
        run_frame(1'b0);
        apply_reset();
        stream = {8'h00, 8'h01, 8'h04, 8'h00, 8'h00};
        run_frame(1'b1);
        apply_reset();

        for (int t = 0; t < 4; t++) begin
            build_random($urandom_range(2, 5));
            if ($urandom_range(0, 1) == 1) stream[5] = 8'($urandom_range(4, 255));
            else if (CSUM_EN) stream[stream.size()-1] ^= 8'h5A;
            run_frame(1'b1);
            if (exp_err) apply_reset();
            else finish_run();
        end

        if (CSUM_EN) begin
            stream = {8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01};
            run_frame(1'b0);
            check("csum_good_run", 32'(load_done), 32'd1);
            finish_run();
            stream = {8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h00};
            run_frame(1'b0);
            check("csum_bad_err", 32'(err), 32'd1);
            apply_reset();
        end

        // Abort after B1 of the first word: no write, then a clean reload.
        stream = {8'h00, 8'h01, 8'h01, 8'h23, 8'h45};
        obs_addr.delete();
        obs_data.delete();
        send_stream(4, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_vals();
        check("abort_no_write", 32'(obs_addr.size()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_write_after", 32'(obs_addr.size()), 32'd0);
        build_random(3);
        run_frame(1'b1);
        finish_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction-memory address width.
REQ-002 SHALL have parameter INSTR_W, fixed 18, instruction width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_valid  input  1  byte-stream source has a byte.
REQ-006 SHALL have port rx_data  input  8  byte from the source.
REQ-007 SHALL have port rx_ready  output  1  loader accepts a byte; transfer when rx_valid && rx_ready.
REQ-008 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-009 SHALL have port imem_addr  output  ADDR_W  instruction-memory word address.
REQ-010 SHALL have port imem_wdata  output  18  instruction word to write.
REQ-011 SHALL have port cpu_finish  input  1  processor finish flag.
REQ-012 SHALL have port cpu_reset  output  1  active-high hold-in-reset for the processor.
REQ-013 SHALL have port load_done  output  1  program loaded, processor running.
REQ-014 SHALL have port err  output  1  sticky protocol error.

Function
REQ-015 SHALL implement states LEN_HI, LEN_LO, B0, B1, B2, WRITE, CHK, RUN, ERROR.
REQ-016 Frame: 16-bit word count N big-endian (LEN_HI, LEN_LO), then N words of 3 bytes each (B0, B1, B2), then optional checksum byte (CHK).
REQ-017 rx_ready SHALL be 1 in LEN_HI, LEN_LO, B0, B1, B2, CHK; 0 in WRITE, RUN, ERROR; a state advances only on a transfer.
REQ-018 At LEN_LO transfer: N==0 or N>2^ADDR_W -> ERROR; else -> B0.
REQ-019 Word assembly: B0 bits[1:0] -> word[17:16], B1 -> word[15:8], B2 -> word[7:0]; B0 bits[7:2] nonzero -> ERROR at that transfer.
REQ-020 After the B2 transfer, WRITE lasts exactly one cycle with imem_we=1, imem_wdata=assembled word, imem_addr=current index; the index increments at the end of WRITE.
REQ-021 From WRITE: if index+1 < N -> B0; else -> CHK when CHECKSUM_EN is defined, otherwise -> RUN.
REQ-022 First word SHALL be written at address 0; consecutive words at consecutive addresses; no wrap, since N is bounded by REQ-018.
REQ-023 cpu_reset SHALL be 1 in every state except RUN; load_done SHALL be 1 only in RUN.
REQ-024 In RUN, cpu_finish=1 -> LEN_HI next cycle: cpu_reset reasserts, index clears to 0, and a new frame is accepted.
REQ-025 ERROR SHALL hold err=1, cpu_reset=1, rx_ready=0 and imem_we=0 until reset.
REQ-026 imem_we SHALL be 0 in every state except WRITE.
REQ-027 A byte with rx_valid=1 while rx_ready=0 SHALL be neither consumed nor lost by the loader (source holds it).

Reset
REQ-028 reset low SHALL immediately force: state LEN_HI, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, index=0, N=0, cpu_reset=1, load_done=0, err=0, checksum=0.
REQ-029 reset asserted mid-frame or during WRITE SHALL abort the frame; the partial word is not written, and the next frame starts at LEN_HI.

Configuration
REQ-030 With macro PROGRAM_LOADER_CHECKSUM_EN defined, the loader SHALL XOR-accumulate every byte from LEN_HI through the last B2 and expect one CHK byte equal to that XOR: match -> RUN, mismatch -> ERROR.
REQ-031 Without PROGRAM_LOADER_CHECKSUM_EN, CHK SHALL be unreachable and no checksum byte is consumed.

Verification
REQ-032 Bytes 00 01 03 FF FF -> one WRITE at addr 0 with data 0x3FFFF, then cpu_reset=0 and load_done=1 (no checksum).
REQ-033 N=2, words 0x00123 and 0x2ABCD, with rx_valid toggling randomly -> writes at addr 0 and 1 with exact data, each imem_we exactly one cycle.
REQ-034 Boundary checks: N=0 -> err=1; N=0x0401 with ADDR_W=10 -> err=1; B0=0x04 -> err=1 with no imem_we in any case.
REQ-035 With CHECKSUM_EN: frame 00 01 01 02 03 followed by checksum 01 -> RUN; same frame with checksum 00 -> ERROR.
REQ-036 In RUN, pulse cpu_finish -> cpu_reset=1 next cycle; a second frame then rewrites from addr 0.
REQ-037 Drop reset low after B1 of the first word -> all outputs take reset values, no write occurs, and a subsequent full frame loads correctly.
